// File: rtl/latch_mem_wide_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : latch_mem_wide_pkg
//  Description : Shared definitions for the wide latch scratch RAM. Holds the
//                bus size codes, a helper that gives the transfer size in
//                bytes, and a ceiling-divide helper that gives the beat count.
//  Revision    : 1.0 - initial release
// ============================================================================
package latch_mem_wide_pkg;

    typedef logic [1:0] txn_code_t;

    // Bus size codes. The same encoding is used for data_write_n and data_read_n.
    localparam txn_code_t TXN_NONE = 2'b11;
    localparam txn_code_t TXN_B    = 2'b00;
    localparam txn_code_t TXN_H    = 2'b01;
    localparam txn_code_t TXN_W    = 2'b10;

    // Number of bytes moved by a transaction with the given size code.
    function automatic logic [2:0] txn_bytes(input txn_code_t code);
        case (code)
            TXN_B:   return 3'd1;
            TXN_H:   return 3'd2;
            TXN_W:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // ceil(num / den). den is always an elaboration-time constant here.
    function automatic logic [2:0] ceil_div(input logic [2:0] num, input int den);
        return 3'((int'(num) + den - 1) / den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/latch_mem_wide_latch.sv
`default_nettype none
// ============================================================================
//  Module      : latch_mem_wide_latch
//  Description : One storage word of the scratch RAM. Transparent while clk
//                and wen are both high; wen and data_in come from
//                negative-edge staging registers, so they are stable for the
//                whole high phase of clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_mem_wide_latch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // Level-sensitive storage: capture data_in during the enabled high phase.
    always_latch begin
        if (clk && wen) begin
            data_out <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/latch_mem_wide.sv
`default_nettype none
// ============================================================================
//  Module      : latch_mem_wide
//  Description : Latch-based scratch RAM for the TinyQV data bus. Serves
//                8/16/32-bit reads and writes, LANES bytes per beat, with
//                address wrap-around and an optional zero-fill after reset.
//                Write lanes are staged on the falling clock edge and written
//                into the byte latches during the following high phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_mem_wide
    import latch_mem_wide_pkg::*;
#(
    parameter int RAM_BYTES = 64,
    parameter int ADDR_BITS = 6,
    parameter int LANES     = 1,
    parameter int ZERO_INIT = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [31:0]          data_in,
    input  logic [1:0]           data_write_n,
    input  logic [1:0]           data_read_n,
    output logic [31:0]          data_out,
    output logic                 data_ready,
    output logic                 init_busy
);

    // Last init pointer value before the fill wraps back to zero.
    localparam logic [ADDR_BITS-1:0] c_last_ptr  = ADDR_BITS'(RAM_BYTES - LANES);
    localparam logic [ADDR_BITS-1:0] c_ptr_step  = ADDR_BITS'(LANES);

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic       w_is_write;
    txn_code_t  w_code;
    logic       w_req;
    logic [2:0] w_nbytes;
    logic [2:0] w_nbeats;

    // A simultaneous read and write is resolved in favour of the write.
    assign w_is_write = (data_write_n != TXN_NONE);
    assign w_code     = w_is_write ? data_write_n : data_read_n;
    assign w_req      = (w_code != TXN_NONE);
    assign w_nbytes   = txn_bytes(w_code);
    assign w_nbeats   = ceil_div(w_nbytes, LANES);

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic [1:0]           r_beat;
    logic                 r_ready;
    logic                 r_busy;
    logic [ADDR_BITS-1:0] r_init_ptr;
    logic [31:0]          r_data_out;

    logic w_beat_act;
    logic w_last_beat;

    // The data_ready cycle never starts a beat, so a held request restarts
    // as a fresh transaction one cycle later.
    assign w_beat_act  = !r_busy && !r_ready && w_req;
    assign w_last_beat = ({1'b0, r_beat} == (w_nbeats - 3'd1));

    // ------------------------------------------------------------------------
    // Per-lane addressing
    // ------------------------------------------------------------------------
    logic [LANES-1:0][3:0]           w_lane_idx;   // byte index within the transaction
    logic [LANES-1:0][ADDR_BITS-1:0] w_bus_addr;   // address driven by the bus request
    logic [LANES-1:0]                w_lane_act;   // lane falls inside the transfer size
    logic [LANES-1:0][ADDR_BITS-1:0] w_lane_addr;  // write address (bus or zero-fill)
    logic [LANES-1:0][7:0]           w_lane_data;
    logic [LANES-1:0]                w_lane_wen;
    logic [LANES-1:0][7:0]           w_rd_byte;

    logic [7:0] w_mem [RAM_BYTES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_idx[k]  = 4'(r_beat) * 4'(LANES) + 4'(k);
        // Address arithmetic is modulo RAM_BYTES through the ADDR_BITS width.
        assign w_bus_addr[k]  = addr_in + ADDR_BITS'(w_lane_idx[k]);
        assign w_lane_act[k]  = (w_lane_idx[k] < {1'b0, w_nbytes});
        assign w_lane_addr[k] = r_busy ? (r_init_ptr + ADDR_BITS'(k)) : w_bus_addr[k];
        assign w_lane_data[k] = r_busy ? 8'h00
                                       : data_in[{w_lane_idx[k][1:0], 3'b000} +: 8];
        assign w_lane_wen[k]  = r_busy || (w_beat_act && w_is_write && w_lane_act[k]);
        assign w_rd_byte[k]   = w_mem[w_bus_addr[k]];
    end

    // ------------------------------------------------------------------------
    // Falling-edge staging of the write lanes
    // ------------------------------------------------------------------------
    logic [LANES-1:0][ADDR_BITS-1:0] r_stg_addr;
    logic [LANES-1:0][7:0]           r_stg_data;
    logic [LANES-1:0]                r_stg_wen;

    // Hold write lanes across the next clk-high phase so latch inputs stay quiet.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stg_addr <= '0;
            r_stg_data <= '0;
            r_stg_wen  <= '0;
        end else begin
            r_stg_addr <= w_lane_addr;
            r_stg_data <= w_lane_data;
            r_stg_wen  <= w_lane_wen;
        end
    end

    // ------------------------------------------------------------------------
    // Byte storage with one-hot write-enable decode
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < RAM_BYTES; i++) begin : g_byte
        logic       w_wen;
        logic [7:0] w_wdata;

        // Select the staged lane (if any) that targets this byte.
        always_comb begin
            w_wen   = 1'b0;
            w_wdata = 8'h00;
            for (int k = 0; k < LANES; k++) begin
                if (r_stg_wen[k] && (r_stg_addr[k] == ADDR_BITS'(i))) begin
                    w_wen   = 1'b1;
                    w_wdata = r_stg_data[k];
                end
            end
        end

        latch_mem_wide_latch #(
            .WIDTH (8)
        ) u_latch (
            .clk      (clk),
            .wen      (w_wen),
            .data_in  (w_wdata),
            .data_out (w_mem[i])
        );
    end

    // ------------------------------------------------------------------------
    // Read data steering
    // ------------------------------------------------------------------------
    logic [31:0] w_dout_nxt;

    // Place each active read lane at its transaction byte position; others hold.
    always_comb begin
        w_dout_nxt = r_data_out;
        if (w_beat_act && !w_is_write) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_lane_act[k]) begin
                    w_dout_nxt[{w_lane_idx[k][1:0], 3'b000} +: 8] = w_rd_byte[k];
                end
            end
        end
    end

    // Register read data at the end of each read beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_dout_nxt;
        end
    end

    // Beat counter, completion pulse and zero-fill sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= (ZERO_INIT != 0);
            r_init_ptr <= '0;
        end else begin
            r_ready <= 1'b0;
            if (r_busy) begin
                r_beat     <= '0;
                r_init_ptr <= r_init_ptr + c_ptr_step;
                if (r_init_ptr == c_last_ptr) begin
                    r_busy <= 1'b0;
                end
            end else if (w_beat_act) begin
                if (w_last_beat) begin
                    r_beat  <= '0;
                    r_ready <= 1'b1;
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end else begin
                // Idle, completion cycle, or a request dropped mid-transaction.
                r_beat <= '0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_ready;
    assign init_busy  = r_busy;

endmodule
`default_nettype wire
